snap_streamer: RTL and testbench

Debug snapshot transmitter for the single-cycle CPU. On request it freezes the core, walks PC, the register file and data memory, and streams one record per element over a valid/ready interface to an external consumer such as a UART bridge or bench monitor. It sits beside `Simple_Single_CPU`, with read-only taps into the RF and data memory and a freeze output into the PC write enable.

---
 rtl/snap_pkg.sv | 25 ++
 rtl/snap_out_reg.sv | 42 ++++
 rtl/snap_streamer.sv | 145 ++++++++++++++
 tb/tb_snap_streamer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/snap_pkg.sv
// Shared types and constants for the snapshot streamer.
package snap_pkg;

  typedef enum logic [1:0] {
    KIND_PC  = 2'd0,
    KIND_REG = 2'd1,
    KIND_MEM = 2'd2
  } rec_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PC    = 3'd1,
    ST_REG   = 3'd2,
    ST_MEM   = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  localparam int DEF_NUM_REGS      = 32;
  localparam int DEF_NUM_MEM_WORDS = 32;
  localparam int DEF_DW            = 32;

  localparam int REC_COUNT_FULL     = 1 + DEF_NUM_REGS + DEF_NUM_MEM_WORDS;
  localparam int REC_COUNT_REG_ONLY = 1 + DEF_NUM_REGS;

endpackage

// File: rtl/snap_out_reg.sv
// Valid/ready output register slice for snapshot records.
module snap_out_reg #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [1:0]    in_kind,
  input  logic [4:0]    in_idx,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  input  logic          ready,
  output logic          valid,
  output logic [1:0]    kind,
  output logic [4:0]    idx,
  output logic [DW-1:0] data,
  output logic          last,
  output logic          free
);

  assign free = !valid || ready;

  // A load only happens while the slot is free, so it also covers the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      kind  <= '0;
      idx   <= '0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      kind  <= in_kind;
      idx   <= in_idx;
      data  <= in_data;
      last  <= in_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/snap_streamer.sv
// Debug snapshot transmitter: freezes the CPU and streams PC, RF and data memory.
// Define SNAP_MEM_EN to include the data-memory walk; otherwise only PC and RF are sent.
module snap_streamer
  import snap_pkg::*;
#(
  parameter int NUM_REGS      = DEF_NUM_REGS,
  parameter int NUM_MEM_WORDS = DEF_NUM_MEM_WORDS,
  parameter int DW            = DEF_DW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          snap_req_i,
  input  logic [DW-1:0] pc_i,
  output logic [4:0]    rf_raddr_o,
  input  logic [DW-1:0] rf_rdata_i,
  output logic [31:0]   dm_raddr_o,
  input  logic [DW-1:0] dm_rdata_i,
  output logic          freeze_o,
  output logic          busy_o,
  output logic          rec_valid_o,
  input  logic          rec_ready_i,
  output logic [1:0]    rec_kind_o,
  output logic [4:0]    rec_idx_o,
  output logic [DW-1:0] rec_data_o,
  output logic          rec_last_o
);

  localparam logic [5:0] REG_LAST = 6'(NUM_REGS - 1);

  state_e        state, state_nxt;
  logic [5:0]    idx, idx_nxt;
  logic          load, slot_free, ld_last;
  rec_kind_e     ld_kind;
  logic [DW-1:0] ld_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Each producer state emits one element whenever the output slot can take it.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    load      = 1'b0;
    ld_kind   = KIND_PC;
    ld_data   = '0;
    ld_last   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (snap_req_i) begin
          state_nxt = ST_PC;
          idx_nxt   = '0;
        end
      end
      ST_PC: begin
        ld_kind = KIND_PC;
        ld_data = pc_i;
        if (slot_free) begin
          load      = 1'b1;
          state_nxt = ST_REG;
          idx_nxt   = '0;
        end
      end
      ST_REG: begin
        ld_kind = KIND_REG;
        ld_data = rf_rdata_i;
        if (slot_free) begin
          load = 1'b1;
          if (idx == REG_LAST) begin
`ifdef SNAP_MEM_EN
            state_nxt = ST_MEM;
`else
            ld_last   = 1'b1;
            state_nxt = ST_DRAIN;
`endif
            idx_nxt = '0;
          end else begin
            idx_nxt = idx + 6'd1;
          end
        end
      end
`ifdef SNAP_MEM_EN
      ST_MEM: begin
        ld_kind = KIND_MEM;
        ld_data = dm_rdata_i;
        if (slot_free) begin
          load = 1'b1;
          if (idx == 6'(NUM_MEM_WORDS - 1)) begin
            ld_last   = 1'b1;
            state_nxt = ST_DRAIN;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 6'd1;
          end
        end
      end
`endif
      ST_DRAIN: begin
        if (rec_valid_o && rec_ready_i) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  assign busy_o     = (state != ST_IDLE);
  assign freeze_o   = busy_o;
  assign rf_raddr_o = (state == ST_REG) ? idx[4:0] : 5'd0;

`ifdef SNAP_MEM_EN
  assign dm_raddr_o = (state == ST_MEM) ? {24'd0, idx, 2'b00} : 32'd0;
`else
  logic unused_mem;
  assign dm_raddr_o = 32'd0;
  assign unused_mem = ^{dm_rdata_i, idx[5]} ^ (NUM_MEM_WORDS != 0);
`endif

  snap_out_reg #(.DW(DW)) u_out (
    .clk     (clk_i),
    .rst     (rst_i),
    .load    (load),
    .in_kind (ld_kind),
    .in_idx  (idx[4:0]),
    .in_data (ld_data),
    .in_last (ld_last),
    .ready   (rec_ready_i),
    .valid   (rec_valid_o),
    .kind    (rec_kind_o),
    .idx     (rec_idx_o),
    .data    (rec_data_o),
    .last    (rec_last_o),
    .free    (slot_free)
  );

endmodule

// File: tb/tb_snap_streamer.sv
// Self-checking bench for snap_streamer against a record-list and slot-occupancy model.
module tb_snap_streamer;
  import snap_pkg::*;

`ifdef SNAP_MEM_EN
  localparam bit MEM_EN = 1'b1;
`else
  localparam bit MEM_EN = 1'b0;
`endif
  localparam int NREC = 1 + 32 + (MEM_EN ? 32 : 0);
  localparam int MAXC = 2 * (REC_COUNT_FULL + REC_COUNT_REG_ONLY) + 60;

  logic        clk = 1'b0;
  logic        rst, snap_req, rec_ready;
  logic [31:0] pc;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata, dm_raddr, dm_rdata;
  logic        freeze, busy, rec_valid, rec_last;
  logic [1:0]  rec_kind;
  logic [4:0]  rec_idx;
  logic [31:0] rec_data;

  logic [31:0] rf_mem [32];
  logic [31:0] dm_mem [32];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign rf_rdata = rf_mem[rf_raddr];
  assign dm_rdata = dm_mem[5'(dm_raddr >> 2)];

  snap_streamer dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .snap_req_i  (snap_req),
    .pc_i        (pc),
    .rf_raddr_o  (rf_raddr),
    .rf_rdata_i  (rf_rdata),
    .dm_raddr_o  (dm_raddr),
    .dm_rdata_i  (dm_rdata),
    .freeze_o    (freeze),
    .busy_o      (busy),
    .rec_valid_o (rec_valid),
    .rec_ready_i (rec_ready),
    .rec_kind_o  (rec_kind),
    .rec_idx_o   (rec_idx),
    .rec_data_o  (rec_data),
    .rec_last_o  (rec_last)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic logic [39:0] packRec(input logic [1:0] k, input logic [4:0] i,
                                          input logic [31:0] d, input logic l);
    return {k, i, d, l};
  endfunction

  // mode 0: ready high, 1: ready toggling, 2: ready random (mostly high)
  task automatic applyStimulus(input int mode, input int abort_at, input int repulse_at);
    logic [39:0] exp_q[$];
    bit          rdy_at[$];
    logic [39:0] cur, prev, want;
    int          n, got, lasts, fall, exp_fall, stable_err, fz_err, dm_err, k, loaded, done;
    bit          v, hs, prev_stall, pulsed;

    exp_q.push_back(packRec(2'd0, 5'd0, pc, 1'b0));
    for (int i = 0; i < 32; i++)
      exp_q.push_back(packRec(2'd1, 5'(i), rf_mem[i], !MEM_EN && (i == 31)));
    if (MEM_EN)
      for (int j = 0; j < 32; j++)
        exp_q.push_back(packRec(2'd2, 5'(j), dm_mem[j], j == 31));
    n = exp_q.size();

    for (int e = 0; e < MAXC + 2; e++) begin
      case (mode)
        0:       rdy_at.push_back(1'b1);
        1:       rdy_at.push_back((e % 2) == 0);
        default: rdy_at.push_back($urandom_range(0, 3) != 0);
      endcase
    end

    // Slot model: a record loads whenever the slot is empty or being emptied.
    v = 1'b0; loaded = 0; done = 0; exp_fall = -1;
    for (int e = 1; e <= MAXC; e++) begin
      hs = v && rdy_at[e];
      if (hs) done++;
      if (done == n) begin
        exp_fall = e;
        break;
      end
      if ((!v || rdy_at[e]) && loaded < n) begin
        loaded++;
        v = 1'b1;
      end else if (hs) begin
        v = 1'b0;
      end
    end

    snap_req  = 1'b1;
    rec_ready = rdy_at[0];
    @(posedge clk); #1;
    snap_req = 1'b0;
    checkOutput("freeze_rise", 64'(freeze), 64'd1);
    checkOutput("busy_rise", 64'(busy), 64'd1);
    checkOutput("valid_at_accept", 64'(rec_valid), 64'd0);

    got = 0; lasts = 0; fall = -1; stable_err = 0; fz_err = 0; dm_err = 0;
    prev_stall = 1'b0; pulsed = 1'b0; prev = '0; k = 0;
    rec_ready = rdy_at[1];
    while (k < MAXC) begin
      @(posedge clk); #1;
      k++;
      if (!busy) begin
        fall = k;
        break;
      end
      cur = packRec(rec_kind, rec_idx, rec_data, rec_last);
      if (freeze !== busy) fz_err++;
      if ((!MEM_EN && dm_raddr !== 32'd0) || dm_raddr[1:0] !== 2'b00) dm_err++;
      if (prev_stall && (!rec_valid || cur !== prev)) stable_err++;
      if (k == 1) checkOutput("pc_valid_after_T1", 64'(rec_valid), 64'd1);

      if (abort_at >= 0 && got == abort_at) begin
        rec_ready = 1'b0;
        rst       = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort_valid", 64'(rec_valid), 64'd0);
        checkOutput("abort_freeze", 64'(freeze), 64'd0);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        return;
      end

      if (!pulsed && repulse_at >= 0 && got == repulse_at) begin
        snap_req = 1'b1;
        pulsed   = 1'b1;
      end else begin
        snap_req = 1'b0;
      end

      rec_ready = rdy_at[k + 1];
      if (rec_valid && rec_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("extra_record", 64'(cur), 64'd0);
        end else begin
          want = exp_q.pop_front();
          checkOutput($sformatf("record%0d", got), 64'(cur), 64'(want));
        end
        got++;
        if (rec_last) lasts++;
      end
      prev_stall = rec_valid && !rec_ready;
      prev       = cur;
    end
    snap_req = 1'b0;

    checkOutput("busy_fall_cycle", 64'(fall), 64'(exp_fall));
    checkOutput("record_count", 64'(got), 64'(n));
    checkOutput("last_count", 64'(lasts), 64'd1);
    checkOutput("stall_stable_errs", 64'(stable_err), 64'd0);
    checkOutput("freeze_busy_errs", 64'(fz_err), 64'd0);
    checkOutput("dm_addr_errs", 64'(dm_err), 64'd0);
    checkOutput("valid_after_done", 64'(rec_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1; snap_req = 1'b0; rec_ready = 1'b0; pc = 32'h40;
    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = 32'(i + 100);
      dm_mem[i] = 32'(i * 3);
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", 64'(rec_valid), 64'd0);
    checkOutput("rst_freeze", 64'(freeze), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_rf_addr", 64'(rf_raddr), 64'd0);
    checkOutput("rst_dm_addr", 64'(dm_raddr), 64'd0);
    checkOutput("rst_rec", 64'(packRec(rec_kind, rec_idx, rec_data, rec_last)), 64'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle_no_req", 64'(busy), 64'd0);

    $display("[TB] directed data, ready high");
    applyStimulus(0, -1, -1);
    $display("[TB] directed data, ready toggling");
    applyStimulus(1, -1, -1);

    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = $urandom;
      dm_mem[i] = $urandom;
    end
    pc = $urandom;
    $display("[TB] request re-pulsed while busy");
    applyStimulus(0, -1, 10);
    @(posedge clk); #1;
    checkOutput("repulse_not_queued", 64'(busy), 64'd0);

    $display("[TB] reset mid-snapshot then restart");
    applyStimulus(2, 20, -1);
    applyStimulus(0, -1, -1);

    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = $urandom;
      dm_mem[i] = $urandom;
    end
    pc = $urandom;
    $display("[TB] back-to-back snapshots");
    applyStimulus(2, -1, -1);
    applyStimulus(0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
